npm_toggle_dout_ddr100: RTL and testbench
=========================================

Name: npm_toggle_dout_ddr100

Overview:
- Active read-burst primitive for the Toggle DDR100 NAND PHY. It is the opposite of the idle driver, which parks every PHY input at zero.
- On a start pulse it:
  - resets the PHY input buffer,
  - asserts CE of one way,
  - drives the RE preamble, toggle and postamble,
  - drains captured 32-bit words from the PI buffer to a valid/ready sink.
- Sits between the NPM primitive mux and NPhy_Toggle, in the same slot as the idle primitive.

Parameters:
- NumberOfWays, 4, number of NAND ways; CE bus is 2*NumberOfWays.
- PreambleCycles, 4, RE-held cycles before toggling (tRPRE), must be ≥1.
- PostambleCycles, 2, RE-held cycles after the last toggle (tRPST), must be ≥1.

Ports:
- iSystemClock  in  1  system clock.
- iReset_n  in  1  asynchronous active-low reset.
- iStart  in  1  one-cycle start request; sampled only when oReady=1.
- iTargetWay  in  NumberOfWays  one-hot way select, latched at iStart.
- iNumOfData  in  16  burst length in 32-bit words, latched at iStart.
- oReady  out  1  high in IDLE only.
- oLastStep  out  1  one-cycle pulse when the burst is complete.
- oReadData  out  32  word to the sink.
- oReadValid  out  1  oReadData valid.
- iReadReady  in  1  sink accepts when oReadValid & iReadReady.
- oPI_Reset  out  1  PHY input-path reset.
- oPI_BUFF_Reset  out  1  PI buffer reset.
- oPI_BUFF_RE  out  1  PI buffer pop.
- oPI_BUFF_WE  out  1  PI buffer write enable.
- oPI_BUFF_OutSel  out  3  PI buffer output select; constant 3'b000.
- iPI_BUFF_Empty  in  1  PI buffer empty.
- iReadData  in  32  PI buffer head, valid the cycle after a pop.
- oPO_ChipEnable  out  2*NumberOfWays  CE phase bits, 2 per way.
- oPO_ReadEnable  out  4  RE quarter-phase pattern.
- oPO_WriteEnable, oPO_AddressLatchEnable, oPO_CommandLatchEnable  out  4 each  constant 0.
- oDQSOutEnable, oDQOutEnable  out  1 each  constant 0 (bus is input during read).

Behaviour:
Reset:
- iReset_n low asynchronously forces state IDLE and clears all counters and flags.
- All outputs take their IDLE values: oReady=1; oLastStep, oReadValid, oPI_BUFF_RE, oPI_BUFF_WE, oPI_Reset, oPI_BUFF_Reset, CE, RE = 0; oReadData=0.
- Reset mid-burst aborts with no oLastStep.

States and transitions (all outputs registered except oPI_BUFF_RE):
- IDLE → on iStart:
  - latch way and N.
  - N=0 → DONE next cycle, no CE, no buffer activity.
  - N≠0 → BRST.
- BRST, 1 cycle: oPI_BUFF_Reset=1, oPI_BUFF_WE=1 armed. → PRE.
- PRE, PreambleCycles cycles:
  - CE bits [2w+1:2w]=2'b11 for the latched way w.
  - RE=4'b0000.
  - → TOGG.
- TOGG, exactly 2*N cycles: CE held, RE=4'b0011 each cycle (2 bytes/cycle, 1 word per 2 cycles). → POST.
- POST, PostambleCycles cycles: CE held, RE=4'b0000. → WAIT.
- WAIT: CE=0, oPI_BUFF_WE=0. → DONE when delivered count = N.
- DONE, 1 cycle: oLastStep=1. → IDLE.
- oPI_BUFF_WE stays high from BRST through POST.

Drain:
- Runs concurrently from PRE through WAIT.
- oPI_BUFF_RE = !iPI_BUFF_Empty & !popPending & (popped < N) & (!oReadValid | iReadReady).
- A pop at cycle t sets popPending for t+1. At t+1, iReadData loads oReadData and oReadValid is set.
- oReadValid clears on accept with no new load.
- Maximum throughput is 1 word per 2 cycles, matching TOGG.
- Popped and delivered counters are 16-bit, with no wrap for N ≤ 65535.

Other rules:
- iStart while not IDLE is ignored.
- A non-one-hot iTargetWay asserts the CE pairs of all set bits.
- Downstream may stall indefinitely in WAIT; the burst never ends before all N words are accepted.
- N must not exceed PI buffer depth (16 words). Larger N is a caller error and behaviour is unspecified.

Decomposition:
- Shared package: state encoding (IDLE, BRST, PRE, TOGG, POST, WAIT, DONE), RE patterns (RE_HOLD=4'b0000, RE_TOGGLE=4'b0011), PI buffer depth constant 16.
- One sub-module: npm_pi_drain, containing the pop/pending/output register and the popped/delivered counters, with a done flag to the FSM.

Test Plan:
- N=4, way 0, iReadReady=1, PHY model fills 1 word/2 cycles → BRST 1, PRE 4, TOGG 8, POST 2; CE[1:0]=2'b11 only; 4 words in order; oLastStep once, then oReady=1.
- N=4, iReadReady low for 10 cycles after the first valid → oReadData stable while stalled; no pop while oReadValid & !iReadReady; all 4 words delivered; DONE only after the 4th accept.
- iStart with N=0 → oLastStep the next cycle; CE, RE, oPI_BUFF_RE never asserted.
- iTargetWay=4'b1000, N=2 → CE=8'b1100_0000 through PRE..POST; other CE bits 0.
- iStart pulsed again during TOGG → ignored, burst length unchanged.
- iReset_n low in cycle 3 of TOGG → all outputs at reset values immediately; no oLastStep; a fresh N=1 burst afterwards completes normally.

Source files
------------

// File: rtl/npm_toggle_dout_ddr100_pkg.sv
// Shared definitions for the Toggle DDR100 read-burst primitive:
// FSM state encoding, RE quarter-phase patterns and PI buffer depth.
package npm_toggle_dout_ddr100_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BRST = 3'd1,
        S_PRE  = 3'd2,
        S_TOGG = 3'd3,
        S_POST = 3'd4,
        S_WAIT = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [3:0] RE_HOLD   = 4'b0000;
    localparam logic [3:0] RE_TOGGLE = 4'b0011;

    localparam int PI_BUFF_DEPTH = 16;

    function automatic logic is_ce_phase(state_t s);
        return (s == S_PRE) || (s == S_TOGG) || (s == S_POST);
    endfunction

endpackage

// File: rtl/npm_toggle_dout_ddr100_if.sv
// Primitive-side bus of the read-burst primitive: start/way/length control,
// valid/ready word sink, PI buffer controls and PHY output-phase pins.
interface npm_toggle_dout_ddr100_if #(
    parameter int NumberOfWays = 4
);
    import npm_toggle_dout_ddr100_pkg::*;

    logic                      iStart;
    logic [NumberOfWays-1:0]   iTargetWay;
    logic [15:0]               iNumOfData;
    logic                      oReady;
    logic                      oLastStep;
    // A word transfers on any cycle where oReadValid & iReadReady; once raised,
    // oReadValid and oReadData hold steady until that transfer happens.
    logic [31:0]               oReadData;
    logic                      oReadValid;
    logic                      iReadReady;
    logic                      oPI_Reset;
    logic                      oPI_BUFF_Reset;
    logic                      oPI_BUFF_RE;
    logic                      oPI_BUFF_WE;
    logic [2:0]                oPI_BUFF_OutSel;
    logic                      iPI_BUFF_Empty;
    logic [31:0]               iReadData;
    logic [2*NumberOfWays-1:0] oPO_ChipEnable;
    logic [3:0]                oPO_ReadEnable;
    logic [3:0]                oPO_WriteEnable;
    logic [3:0]                oPO_AddressLatchEnable;
    logic [3:0]                oPO_CommandLatchEnable;
    logic                      oDQSOutEnable;
    logic                      oDQOutEnable;
    state_t                    oDbgState;

    modport slave (
        input  iStart, iTargetWay, iNumOfData, iReadReady, iPI_BUFF_Empty, iReadData,
        output oReady, oLastStep, oReadData, oReadValid,
        output oPI_Reset, oPI_BUFF_Reset, oPI_BUFF_RE, oPI_BUFF_WE, oPI_BUFF_OutSel,
        output oPO_ChipEnable, oPO_ReadEnable, oPO_WriteEnable,
        output oPO_AddressLatchEnable, oPO_CommandLatchEnable,
        output oDQSOutEnable, oDQOutEnable, oDbgState
    );

    modport master (
        output iStart, iTargetWay, iNumOfData, iReadReady, iPI_BUFF_Empty, iReadData,
        input  oReady, oLastStep, oReadData, oReadValid,
        input  oPI_Reset, oPI_BUFF_Reset, oPI_BUFF_RE, oPI_BUFF_WE, oPI_BUFF_OutSel,
        input  oPO_ChipEnable, oPO_ReadEnable, oPO_WriteEnable,
        input  oPO_AddressLatchEnable, oPO_CommandLatchEnable,
        input  oDQSOutEnable, oDQOutEnable, oDbgState
    );

endinterface

// File: rtl/npm_pi_drain.sv
// Drains captured words from the PI buffer into a registered valid/ready
// output stage; the buffer head appears one cycle after each pop.
module npm_pi_drain (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [15:0] i_num,
    input  logic        i_empty,
    input  logic [31:0] i_data,
    input  logic        i_ready,
    output logic        o_pop,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_done
);
    logic        r_pending;
    logic        r_valid;
    logic [31:0] r_data;
    logic [15:0] r_popped;
    logic [15:0] r_delivered;
    logic        w_pop;
    logic        w_accept;

    assign w_accept = r_valid & i_ready;
    // Only one pop in flight, and only when the output slot frees up this cycle.
    assign w_pop = i_enable & ~i_empty & ~r_pending & (r_popped < i_num) & (~r_valid | i_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending   <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_popped    <= '0;
            r_delivered <= '0;
        end else if (i_clear) begin
            r_pending   <= 1'b0;
            r_valid     <= 1'b0;
            r_popped    <= '0;
            r_delivered <= '0;
        end else begin
            r_pending <= w_pop;
            if (w_pop) r_popped <= r_popped + 16'd1;
            if (w_accept) r_delivered <= r_delivered + 16'd1;
            if (r_pending) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_pop   = w_pop;
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_done  = (r_delivered == i_num);

endmodule

// File: rtl/npm_toggle_dout_ddr100.sv
// Toggle DDR100 read-burst primitive: buffer reset, CE of one way, RE
// preamble/toggle/postamble, then waits until the sink has taken N words.
module npm_toggle_dout_ddr100 #(
    parameter int NumberOfWays    = 4,
    parameter int PreambleCycles  = 4,
    parameter int PostambleCycles = 2
) (
    input logic                     iSystemClock,
    input logic                     iReset_n,
    npm_toggle_dout_ddr100_if.slave bus
);
    import npm_toggle_dout_ddr100_pkg::*;

    localparam logic [16:0] PRE_LOAD  = 17'(PreambleCycles - 1);
    localparam logic [16:0] POST_LOAD = 17'(PostambleCycles - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [16:0]               r_cnt;
    logic [16:0]               w_cnt_next;
    logic [NumberOfWays-1:0]   r_way;
    logic [15:0]               r_num;
    logic                      r_ready;
    logic                      r_last;
    logic                      r_we;
    logic                      r_buff_rst;
    logic [3:0]                r_re;
    logic [2*NumberOfWays-1:0] r_ce;
    logic [2*NumberOfWays-1:0] w_ce_pattern;
    logic                      w_drain_done;
    logic                      w_drain_en;
    logic                      w_start;

    assign w_start    = (r_state == S_IDLE) & bus.iStart;
    assign w_drain_en = (r_state == S_PRE) | (r_state == S_TOGG) | (r_state == S_POST) | (r_state == S_WAIT);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: if (bus.iStart) w_state_next = (bus.iNumOfData == 16'd0) ? S_DONE : S_BRST;
            S_BRST: begin
                w_state_next = S_PRE;
                w_cnt_next   = PRE_LOAD;
            end
            S_PRE: begin
                if (r_cnt == '0) begin
                    w_state_next = S_TOGG;
                    w_cnt_next   = {r_num, 1'b0} - 17'd1;
                end else begin
                    w_cnt_next = r_cnt - 17'd1;
                end
            end
            S_TOGG: begin
                if (r_cnt == '0) begin
                    w_state_next = S_POST;
                    w_cnt_next   = POST_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 17'd1;
                end
            end
            S_POST: begin
                if (r_cnt == '0) w_state_next = S_WAIT;
                else             w_cnt_next   = r_cnt - 17'd1;
            end
            S_WAIT:  if (w_drain_done) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ce_pattern = '0;
        for (int i = 0; i < NumberOfWays; i++) w_ce_pattern[2*i +: 2] = {2{r_way[i]}};
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_way      <= '0;
            r_num      <= '0;
            r_ready    <= 1'b1;
            r_last     <= 1'b0;
            r_we       <= 1'b0;
            r_buff_rst <= 1'b0;
            r_re       <= RE_HOLD;
            r_ce       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            if (w_start) begin
                r_way <= bus.iTargetWay;
                r_num <= bus.iNumOfData;
            end
            r_ready    <= (w_state_next == S_IDLE);
            r_last     <= (w_state_next == S_DONE);
            r_we       <= (w_state_next == S_BRST) | is_ce_phase(w_state_next);
            r_buff_rst <= (w_state_next == S_BRST);
            r_re       <= (w_state_next == S_TOGG) ? RE_TOGGLE : RE_HOLD;
            r_ce       <= is_ce_phase(w_state_next) ? w_ce_pattern : '0;
        end
    end

    npm_pi_drain u_drain (
        .i_clk    (iSystemClock),
        .i_rst_n  (iReset_n),
        .i_clear  (r_state == S_BRST),
        .i_enable (w_drain_en),
        .i_num    (r_num),
        .i_empty  (bus.iPI_BUFF_Empty),
        .i_data   (bus.iReadData),
        .i_ready  (bus.iReadReady),
        .o_pop    (bus.oPI_BUFF_RE),
        .o_data   (bus.oReadData),
        .o_valid  (bus.oReadValid),
        .o_done   (w_drain_done)
    );

    assign bus.oReady                 = r_ready;
    assign bus.oLastStep              = r_last;
    assign bus.oPI_Reset              = r_buff_rst;
    assign bus.oPI_BUFF_Reset         = r_buff_rst;
    assign bus.oPI_BUFF_WE            = r_we;
    assign bus.oPI_BUFF_OutSel        = 3'b000;
    assign bus.oPO_ChipEnable         = r_ce;
    assign bus.oPO_ReadEnable         = r_re;
    assign bus.oPO_WriteEnable        = 4'b0000;
    assign bus.oPO_AddressLatchEnable = 4'b0000;
    assign bus.oPO_CommandLatchEnable = 4'b0000;
    assign bus.oDQSOutEnable          = 1'b0;
    assign bus.oDQOutEnable           = 1'b0;
    assign bus.oDbgState              = r_state;

endmodule

// File: tb/tb_npm_toggle_dout_ddr100.sv
// Directed bench for npm_toggle_dout_ddr100 with a small PI buffer model that
// captures one word per two RE-toggle cycles.
module tb_npm_toggle_dout_ddr100;
    import npm_toggle_dout_ddr100_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    npm_toggle_dout_ddr100_if #(.NumberOfWays(4)) bus();

    npm_toggle_dout_ddr100 #(
        .NumberOfWays(4), .PreambleCycles(4), .PostambleCycles(2)
    ) dut (
        .iSystemClock (clk),
        .iReset_n     (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PI buffer model: samples controls at negedge, updates 1 time unit after posedge.
    logic [31:0] phy_q[$];
    int          tog_cnt;
    int          word_idx;
    initial begin
        logic s_rst, s_pop, s_tog;
        bus.iPI_BUFF_Empty = 1'b1;
        bus.iReadData      = 32'h0;
        tog_cnt  = 0;
        word_idx = 0;
        forever begin
            @(negedge clk);
            s_rst = bus.oPI_BUFF_Reset;
            s_pop = bus.oPI_BUFF_RE;
            s_tog = bus.oPI_BUFF_WE && (bus.oPO_ReadEnable == RE_TOGGLE);
            @(posedge clk);
            #1;
            if (s_rst) begin
                phy_q.delete();
                tog_cnt  = 0;
                word_idx = 0;
            end else begin
                if (s_pop && phy_q.size() > 0) bus.iReadData = phy_q.pop_front();
                if (s_tog) begin
                    tog_cnt++;
                    if (tog_cnt % 2 == 0) begin
                        phy_q.push_back(32'hCAFE_0000 + 32'(word_idx));
                        word_idx++;
                    end
                end
            end
            bus.iPI_BUFF_Empty = (phy_q.size() == 0);
        end
    end

    // Monitor: collects accepted words and per-burst observations.
    logic [31:0] rcv_q[$];
    logic [31:0] exp_q[$];
    int          mon_sc[8];
    int          mon_last, mon_words_at_last, mon_ce_bad, mon_re_seen, mon_pop_seen;
    int          mon_stall_err, mon_stall_cycles;
    logic [7:0]  mon_ce_or;
    logic [7:0]  tb_ce_exp;
    int          clr_req, clr_ack;
    initial begin
        logic        p_valid, p_ready;
        logic [31:0] p_data;
        p_valid = 1'b0; p_ready = 1'b0; p_data = '0;
        clr_ack = -1;
        forever begin
            @(negedge clk);
            if (clr_req != clr_ack) begin
                rcv_q.delete();
                for (int i = 0; i < 8; i++) mon_sc[i] = 0;
                mon_last = 0; mon_words_at_last = -1; mon_ce_bad = 0; mon_re_seen = 0;
                mon_pop_seen = 0; mon_stall_err = 0; mon_stall_cycles = 0; mon_ce_or = '0;
                clr_ack = clr_req;
            end
            mon_sc[int'(bus.oDbgState)]++;
            mon_ce_or = mon_ce_or | bus.oPO_ChipEnable;
            if (bus.oPO_ChipEnable !== 8'h00 && bus.oPO_ChipEnable !== tb_ce_exp) mon_ce_bad++;
            if (bus.oPO_ReadEnable !== 4'b0000) mon_re_seen++;
            if (bus.oPI_BUFF_RE) mon_pop_seen++;
            if (p_valid && !p_ready && rst_n) begin
                mon_stall_cycles++;
                if (!bus.oReadValid || bus.oReadData !== p_data) mon_stall_err++;
            end
            if (bus.oReadValid && !bus.iReadReady && bus.oPI_BUFF_RE) mon_stall_err++;
            if (bus.oReadValid && bus.iReadReady) rcv_q.push_back(bus.oReadData);
            if (bus.oLastStep) begin
                mon_last++;
                mon_words_at_last = rcv_q.size();
            end
            p_valid = bus.oReadValid; p_ready = bus.iReadReady; p_data = bus.oReadData;
        end
    end

    task automatic clear_mon(input logic [7:0] ce_exp);
        tb_ce_exp = ce_exp;
        clr_req++;
    endtask

    task automatic start_burst(input logic [3:0] way, input logic [15:0] n);
        @(posedge clk); #1;
        bus.iStart = 1'b1; bus.iTargetWay = way; bus.iNumOfData = n;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
    endtask

    task automatic wait_last();
        for (int c = 0; c < 300 && mon_last == 0; c++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic wait_state(input state_t s);
        for (int c = 0; c < 100 && bus.oDbgState != s; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (bus.oReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", bus.oReady); end
        n_checks++; if (bus.oLastStep !== 1'b0) begin n_fail++; $display("FAIL rst_last got %b exp 0", bus.oLastStep); end
        n_checks++; if (bus.oReadValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.oReadValid); end
        n_checks++; if (bus.oReadData !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h exp 0", bus.oReadData); end
        n_checks++; if (bus.oPO_ChipEnable !== 8'h00) begin n_fail++; $display("FAIL rst_ce got %h exp 00", bus.oPO_ChipEnable); end
        n_checks++; if (bus.oPO_ReadEnable !== 4'h0) begin n_fail++; $display("FAIL rst_re got %h exp 0", bus.oPO_ReadEnable); end
        n_checks++; if ({bus.oPI_BUFF_RE, bus.oPI_BUFF_WE, bus.oPI_Reset, bus.oPI_BUFF_Reset} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_pi got %b exp 0000", {bus.oPI_BUFF_RE, bus.oPI_BUFF_WE, bus.oPI_Reset, bus.oPI_BUFF_Reset}); end
        n_checks++; if (bus.oDbgState !== S_IDLE) begin n_fail++; $display("FAIL rst_state got %0d exp 0", bus.oDbgState); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_burst();
        clear_mon(8'h03);
        bus.iReadReady = 1'b1;
        start_burst(4'b0001, 16'd4);
        wait_last();
        n_checks++; if (mon_sc[S_BRST] !== 1) begin n_fail++; $display("FAIL basic_brst got %0d exp 1", mon_sc[S_BRST]); end
        n_checks++; if (mon_sc[S_PRE] !== 4) begin n_fail++; $display("FAIL basic_pre got %0d exp 4", mon_sc[S_PRE]); end
        n_checks++; if (mon_sc[S_TOGG] !== 8) begin n_fail++; $display("FAIL basic_togg got %0d exp 8", mon_sc[S_TOGG]); end
        n_checks++; if (mon_sc[S_POST] !== 2) begin n_fail++; $display("FAIL basic_post got %0d exp 2", mon_sc[S_POST]); end
        n_checks++; if (mon_ce_or !== 8'h03 || mon_ce_bad !== 0) begin n_fail++; $display("FAIL basic_ce got %h bad %0d exp 03", mon_ce_or, mon_ce_bad); end
        exp_q = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
        n_checks++; if (rcv_q.size() !== 4) begin n_fail++; $display("FAIL basic_count got %0d exp 4", rcv_q.size()); end
        for (int i = 0; i < 4 && i < rcv_q.size(); i++) begin
            n_checks++; if (rcv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d got %h exp %h", i, rcv_q[i], exp_q[i]); end
        end
        n_checks++; if (mon_last !== 1) begin n_fail++; $display("FAIL basic_last got %0d exp 1", mon_last); end
        n_checks++; if (bus.oReady !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b exp 1", bus.oReady); end
    endtask

    task automatic test_stall();
        clear_mon(8'h03);
        bus.iReadReady = 1'b1;
        start_burst(4'b0001, 16'd4);
        for (int c = 0; c < 100 && !bus.oReadValid; c++) begin
            @(posedge clk); #1;
        end
        bus.iReadReady = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (bus.oReadValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b exp 1", bus.oReadValid); end
        n_checks++; if (rcv_q.size() !== 0) begin n_fail++; $display("FAIL stall_none got %0d exp 0", rcv_q.size()); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (mon_last !== 0) begin n_fail++; $display("FAIL stall_early_last got %0d exp 0", mon_last); end
        bus.iReadReady = 1'b1;
        wait_last();
        n_checks++; if (mon_stall_cycles < 10) begin n_fail++; $display("FAIL stall_cycles got %0d exp >=10", mon_stall_cycles); end
        n_checks++; if (mon_stall_err !== 0) begin n_fail++; $display("FAIL stall_hold got %0d exp 0", mon_stall_err); end
        n_checks++; if (mon_words_at_last !== 4) begin n_fail++; $display("FAIL stall_done_after got %0d exp 4", mon_words_at_last); end
        exp_q = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
        for (int i = 0; i < 4 && i < rcv_q.size(); i++) begin
            n_checks++; if (rcv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_word%0d got %h exp %h", i, rcv_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_len();
        clear_mon(8'h00);
        start_burst(4'b0001, 16'd0);
        n_checks++; if (bus.oLastStep !== 1'b1) begin n_fail++; $display("FAIL zero_last got %b exp 1", bus.oLastStep); end
        @(posedge clk); #1;
        n_checks++; if (bus.oReady !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b exp 1", bus.oReady); end
        @(posedge clk); #1;
        n_checks++; if (mon_ce_or !== 8'h00 || mon_re_seen !== 0 || mon_pop_seen !== 0) begin
            n_fail++; $display("FAIL zero_quiet got ce %h re %0d pop %0d exp 0", mon_ce_or, mon_re_seen, mon_pop_seen); end
        n_checks++; if (mon_sc[S_BRST] !== 0) begin n_fail++; $display("FAIL zero_brst got %0d exp 0", mon_sc[S_BRST]); end
    endtask

    task automatic test_way3();
        clear_mon(8'hC0);
        bus.iReadReady = 1'b1;
        start_burst(4'b1000, 16'd2);
        wait_last();
        n_checks++; if (mon_ce_or !== 8'hC0 || mon_ce_bad !== 0) begin n_fail++; $display("FAIL way3_ce got %h bad %0d exp c0", mon_ce_or, mon_ce_bad); end
        n_checks++; if (mon_sc[S_TOGG] !== 4) begin n_fail++; $display("FAIL way3_togg got %0d exp 4", mon_sc[S_TOGG]); end
        n_checks++; if (rcv_q.size() !== 2) begin n_fail++; $display("FAIL way3_count got %0d exp 2", rcv_q.size()); end
    endtask

    task automatic test_restart_ignored();
        clear_mon(8'h03);
        bus.iReadReady = 1'b1;
        start_burst(4'b0001, 16'd3);
        wait_state(S_TOGG);
        bus.iStart = 1'b1; bus.iTargetWay = 4'b0100; bus.iNumOfData = 16'd9;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        wait_last();
        n_checks++; if (mon_sc[S_TOGG] !== 6) begin n_fail++; $display("FAIL restart_togg got %0d exp 6", mon_sc[S_TOGG]); end
        n_checks++; if (rcv_q.size() !== 3) begin n_fail++; $display("FAIL restart_count got %0d exp 3", rcv_q.size()); end
        n_checks++; if (mon_ce_or !== 8'h03) begin n_fail++; $display("FAIL restart_ce got %h exp 03", mon_ce_or); end
        n_checks++; if (mon_last !== 1) begin n_fail++; $display("FAIL restart_last got %0d exp 1", mon_last); end
    endtask

    task automatic test_mid_reset();
        clear_mon(8'h03);
        bus.iReadReady = 1'b1;
        start_burst(4'b0001, 16'd4);
        wait_state(S_TOGG);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.oReady !== 1'b1 || bus.oDbgState !== S_IDLE) begin n_fail++; $display("FAIL mrst_idle got rdy %b st %0d exp 1 0", bus.oReady, bus.oDbgState); end
        n_checks++; if (bus.oPO_ChipEnable !== 8'h00 || bus.oPO_ReadEnable !== 4'h0) begin n_fail++; $display("FAIL mrst_pins got ce %h re %h exp 0", bus.oPO_ChipEnable, bus.oPO_ReadEnable); end
        n_checks++; if ({bus.oReadValid, bus.oPI_BUFF_RE, bus.oPI_BUFF_WE, bus.oLastStep} !== 4'b0000) begin
            n_fail++; $display("FAIL mrst_flags got %b exp 0000", {bus.oReadValid, bus.oPI_BUFF_RE, bus.oPI_BUFF_WE, bus.oLastStep}); end
        n_checks++; if (bus.oReadData !== 32'h0) begin n_fail++; $display("FAIL mrst_data got %h exp 0", bus.oReadData); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (mon_last !== 0) begin n_fail++; $display("FAIL mrst_nolast got %0d exp 0", mon_last); end
        clear_mon(8'h03);
        start_burst(4'b0001, 16'd1);
        wait_last();
        n_checks++; if (rcv_q.size() !== 1) begin n_fail++; $display("FAIL mrst_count got %0d exp 1", rcv_q.size()); end
        else begin
            n_checks++; if (rcv_q[0] !== 32'hCAFE_0000) begin n_fail++; $display("FAIL mrst_word got %h exp cafe0000", rcv_q[0]); end
        end
        n_checks++; if (mon_last !== 1 || mon_sc[S_TOGG] !== 2) begin n_fail++; $display("FAIL mrst_burst got last %0d togg %0d exp 1 2", mon_last, mon_sc[S_TOGG]); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr_req  = 0;
        tb_ce_exp = 8'h00;
        rst_n = 1'b0;
        bus.iStart = 1'b0; bus.iTargetWay = 4'b0000; bus.iNumOfData = 16'd0; bus.iReadReady = 1'b0;
        test_reset();
        test_basic_burst();
        test_stall();
        test_zero_len();
        test_way3();
        test_restart_ignored();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
